// File: rtl/park_allocator_if.sv
//------------------------------------------------------------------------------
// Module      : park_allocator_if
// Description : Request/ticket bundle between the parking front-end, the slot
//               allocator and the token_production block.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface park_allocator_if;
    logic       entry_req;
    logic       exit_req;
    logic [2:0] exit_slot;
    logic [2:0] exit_token;
    logic [2:0] token_in;
    logic [2:0] park_number;
    logic [2:0] pattern;
    logic [2:0] token_out;
    logic [2:0] token_slot;
    logic       token_valid;
    logic       entry_reject;
    logic       exit_ok;
    logic       exit_err;
    logic [7:0] occupancy;
    logic [3:0] free_count;
    logic       entry_full;
    logic [7:0] stat_entries;
    logic [7:0] stat_rejects;
    logic [7:0] stat_exit_errs;

    modport slave (
        input  entry_req, exit_req, exit_slot, exit_token, token_in,
        output park_number, pattern, token_out, token_slot, token_valid,
               entry_reject, exit_ok, exit_err, occupancy, free_count,
               entry_full, stat_entries, stat_rejects, stat_exit_errs
    );

    modport master (
        output entry_req, exit_req, exit_slot, exit_token, token_in,
        input  park_number, pattern, token_out, token_slot, token_valid,
               entry_reject, exit_ok, exit_err, occupancy, free_count,
               entry_full, stat_entries, stat_rejects, stat_exit_errs
    );
endinterface

`default_nettype wire

// File: rtl/park_allocator.sv
//------------------------------------------------------------------------------
// Module      : park_allocator
// Description : Parking slot allocator: lowest-free-slot entry allocation with
//               token capture, and token-checked exit. Optional statistics
//               counters are built when PARK_ALLOC_STATS_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module park_allocator #(
    parameter int NUM_SLOTS = 8,
    parameter int PAT_STEP  = 3,
    parameter int PAT_INIT  = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    park_allocator_if.slave    bus
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ALLOC    = 2'd1;
    localparam logic [1:0] c_ISSUE    = 2'd2;
    localparam logic [1:0] c_EXIT_CHK = 2'd3;

    logic [1:0] r_state;
    logic       r_entry_d;
    logic       r_exit_d;
    logic       r_ent_pend;
    logic       r_ext_pend;
    logic [2:0] r_exit_slot;
    logic [2:0] r_exit_token;
    logic [2:0] r_pat_cnt;
    logic [2:0] r_slot_pat [0:7];
    logic [7:0] r_occ;
    logic [3:0] r_free_cnt;
    logic       r_full;
    logic [2:0] r_park_number;
    logic [2:0] r_pattern;
    logic [2:0] r_token_out;
    logic [2:0] r_token_slot;
    logic       r_token_valid;
    logic       r_entry_reject;
    logic       r_exit_ok;
    logic       r_exit_err;

    logic       w_entry_rise;
    logic       w_exit_rise;
    logic       w_take_ent;
    logic       w_take_ext;
    logic [2:0] w_free_slot;
    logic       w_exit_good;

    assign w_entry_rise = bus.entry_req & ~r_entry_d;
    assign w_exit_rise  = bus.exit_req  & ~r_exit_d;
    assign w_take_ext   = (r_state == c_IDLE) && r_ext_pend;
    assign w_take_ent   = (r_state == c_IDLE) && !r_ext_pend && r_ent_pend;

    // Scan downward so the lowest free usable slot wins.
    always_comb begin
        w_free_slot = 3'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_occ[i]) begin
                w_free_slot = 3'(i);
            end
        end
    end

    assign w_exit_good = ({1'b0, r_exit_slot} < 4'(NUM_SLOTS)) && r_occ[r_exit_slot]
                         && (r_exit_token == (r_exit_slot ^ r_slot_pat[r_exit_slot]));

    // Edge detection and pending flags; an edge while already pending is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry_d    <= bus.entry_req;
            r_exit_d     <= bus.exit_req;
            r_ent_pend   <= 1'b0;
            r_ext_pend   <= 1'b0;
            r_exit_slot  <= 3'd0;
            r_exit_token <= 3'd0;
        end else begin
            r_entry_d  <= bus.entry_req;
            r_exit_d   <= bus.exit_req;
            r_ent_pend <= r_ent_pend ? !w_take_ent : w_entry_rise;
            r_ext_pend <= r_ext_pend ? !w_take_ext : w_exit_rise;
            if (w_exit_rise && !r_ext_pend) begin
                r_exit_slot  <= bus.exit_slot;
                r_exit_token <= bus.exit_token;
            end
        end
    end

    // Result registers are loaded on the transition into ISSUE / EXIT_CHK so
    // that the pulses and the captured ticket are visible during those states.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_pat_cnt      <= 3'(PAT_INIT);
            r_occ          <= 8'h00;
            r_free_cnt     <= 4'(NUM_SLOTS);
            r_full         <= 1'b0;
            r_park_number  <= 3'd0;
            r_pattern      <= 3'd0;
            r_token_out    <= 3'd0;
            r_token_slot   <= 3'd0;
            r_token_valid  <= 1'b0;
            r_entry_reject <= 1'b0;
            r_exit_ok      <= 1'b0;
            r_exit_err     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_slot_pat[i] <= 3'd0;
            end
        end else begin
            r_token_valid  <= 1'b0;
            r_entry_reject <= 1'b0;
            r_exit_ok      <= 1'b0;
            r_exit_err     <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (r_ext_pend) begin
                        r_state <= c_EXIT_CHK;
                        if (w_exit_good) begin
                            r_exit_ok          <= 1'b1;
                            r_occ[r_exit_slot] <= 1'b0;
                            r_free_cnt         <= r_free_cnt + 4'd1;
                            r_full             <= 1'b0;
                        end else begin
                            r_exit_err <= 1'b1;
                        end
                    end else if (r_ent_pend) begin
                        if (r_full) begin
                            r_entry_reject <= 1'b1;
                        end else begin
                            r_state       <= c_ALLOC;
                            r_park_number <= w_free_slot;
                            r_pattern     <= r_pat_cnt;
                        end
                    end
                end
                c_ALLOC: begin
                    r_state                   <= c_ISSUE;
                    r_token_out               <= bus.token_in;
                    r_token_slot              <= r_park_number;
                    r_token_valid             <= 1'b1;
                    r_occ[r_park_number]      <= 1'b1;
                    r_slot_pat[r_park_number] <= r_pat_cnt;
                    r_pat_cnt                 <= r_pat_cnt + 3'(PAT_STEP);
                    r_free_cnt                <= r_free_cnt - 4'd1;
                    r_full                    <= (r_free_cnt == 4'd1);
                end
                c_ISSUE:    r_state <= c_IDLE;
                c_EXIT_CHK: r_state <= c_IDLE;
                default:    r_state <= c_IDLE;
            endcase
        end
    end

`ifdef PARK_ALLOC_STATS_EN
    logic [7:0] r_stat_entries;
    logic [7:0] r_stat_rejects;
    logic [7:0] r_stat_exit_errs;

    // Saturating event counters, stepped one cycle after each pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_entries   <= 8'd0;
            r_stat_rejects   <= 8'd0;
            r_stat_exit_errs <= 8'd0;
        end else begin
            if (r_token_valid && (r_stat_entries != 8'hFF)) begin
                r_stat_entries <= r_stat_entries + 8'd1;
            end
            if (r_entry_reject && (r_stat_rejects != 8'hFF)) begin
                r_stat_rejects <= r_stat_rejects + 8'd1;
            end
            if (r_exit_err && (r_stat_exit_errs != 8'hFF)) begin
                r_stat_exit_errs <= r_stat_exit_errs + 8'd1;
            end
        end
    end

    assign bus.stat_entries   = r_stat_entries;
    assign bus.stat_rejects   = r_stat_rejects;
    assign bus.stat_exit_errs = r_stat_exit_errs;
`else
    assign bus.stat_entries   = 8'd0;
    assign bus.stat_rejects   = 8'd0;
    assign bus.stat_exit_errs = 8'd0;
`endif

    assign bus.park_number  = r_park_number;
    assign bus.pattern      = r_pattern;
    assign bus.token_out    = r_token_out;
    assign bus.token_slot   = r_token_slot;
    assign bus.token_valid  = r_token_valid;
    assign bus.entry_reject = r_entry_reject;
    assign bus.exit_ok      = r_exit_ok;
    assign bus.exit_err     = r_exit_err;
    assign bus.occupancy    = r_occ;
    assign bus.free_count   = r_free_cnt;
    assign bus.entry_full   = r_full;

endmodule

`default_nettype wire

// File: tb/tb_park_allocator.sv
//------------------------------------------------------------------------------
// Module      : tb_park_allocator
// Description : Self-checking bench for park_allocator with a slot-list model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_park_allocator;
    localparam int NUM_SLOTS = 8;
    localparam int PAT_STEP  = 3;
    localparam int PAT_INIT  = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    park_allocator_if bus();

    // token_production stand-in: token = slot XOR pattern.
    assign bus.token_in = bus.park_number ^ bus.pattern;

    park_allocator #(
        .NUM_SLOTS (NUM_SLOTS),
        .PAT_STEP  (PAT_STEP),
        .PAT_INIT  (PAT_INIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model of the lot
    bit m_occ [8];
    int m_slot_pat [8];
    int m_pat;
    int m_entries, m_rejects, m_errs;

    // Observations of one transaction window
    int o_tv_lat, o_rej_lat, o_ok_lat, o_err_lat;
    int o_tv_cnt, o_rej_cnt, o_ok_cnt, o_err_cnt;
    logic [2:0] o_tok, o_tslot, o_pn, o_pat;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_occ[i] = 1'b0;
            m_slot_pat[i] = 0;
        end
        m_pat = PAT_INIT;
        m_entries = 0; m_rejects = 0; m_errs = 0;
    endfunction

    function automatic logic [7:0] model_occ_vec();
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 8; i++) v[i] = m_occ[i];
        return v;
    endfunction

    function automatic int model_free();
        int n = 0;
        for (int i = 0; i < NUM_SLOTS; i++) if (!m_occ[i]) n++;
        return n;
    endfunction

    // Returns -1 for a reject, else the issued slot; also returns pattern/token.
    function automatic int model_entry(output int pat, output int tok);
        pat = 0; tok = 0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!m_occ[i]) begin
                pat = m_pat;
                tok = i ^ m_pat;
                m_occ[i] = 1'b1;
                m_slot_pat[i] = m_pat;
                m_pat = (m_pat + PAT_STEP) % 8;
                if (m_entries < 255) m_entries++;
                return i;
            end
        end
        if (m_rejects < 255) m_rejects++;
        return -1;
    endfunction

    function automatic bit model_exit(input int slot, input int tok);
        bit good = (slot < NUM_SLOTS) && m_occ[slot] && (tok == (slot ^ m_slot_pat[slot]));
        if (good) m_occ[slot] = 1'b0;
        else if (m_errs < 255) m_errs++;
        return good;
    endfunction

    task automatic send(input bit ent, input bit ext, input logic [2:0] slot, input logic [2:0] tok);
        @(negedge clk);
        bus.exit_slot  = slot;
        bus.exit_token = tok;
        bus.entry_req  = ent;
        bus.exit_req   = ext;
        o_tv_lat = 0; o_rej_lat = 0; o_ok_lat = 0; o_err_lat = 0;
        o_tv_cnt = 0; o_rej_cnt = 0; o_ok_cnt = 0; o_err_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.entry_req = 1'b0;
                bus.exit_req  = 1'b0;
            end
            if (bus.token_valid === 1'b1) begin
                if (o_tv_cnt == 0) begin
                    o_tv_lat = c; o_tok = bus.token_out; o_tslot = bus.token_slot;
                    o_pn = bus.park_number; o_pat = bus.pattern;
                end
                o_tv_cnt++;
            end
            if (bus.entry_reject === 1'b1) begin if (o_rej_cnt == 0) o_rej_lat = c; o_rej_cnt++; end
            if (bus.exit_ok === 1'b1)      begin if (o_ok_cnt == 0)  o_ok_lat = c;  o_ok_cnt++;  end
            if (bus.exit_err === 1'b1)     begin if (o_err_cnt == 0) o_err_lat = c; o_err_cnt++; end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        bus.entry_req = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        bus.entry_req = 1'b0;
    endtask

    task automatic test_reset();
        int tv = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.token_valid || bus.entry_reject || bus.exit_ok || bus.exit_err) tv++;
        end
        checks++;
        if (tv != 0) begin failures++; $display("FAIL reset_pulses: saw %0d pulse cycles, required 0", tv); end
        checks++;
        if (bus.occupancy !== 8'h00 || bus.free_count !== 4'(NUM_SLOTS) || bus.entry_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_lot: occ=%h free=%0d full=%b, required 00/%0d/0", bus.occupancy, bus.free_count, bus.entry_full, NUM_SLOTS);
        end
        checks++;
        if ({bus.park_number, bus.pattern, bus.token_out, bus.token_slot} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: pn=%0d pat=%0d tok=%0d tslot=%0d, required all 0", bus.park_number, bus.pattern, bus.token_out, bus.token_slot);
        end
        checks++;
        if ({bus.stat_entries, bus.stat_rejects, bus.stat_exit_errs} !== 24'h0) begin
            failures++;
            $display("FAIL reset_stats: %0d/%0d/%0d, required 0/0/0", bus.stat_entries, bus.stat_rejects, bus.stat_exit_errs);
        end
    endtask

    task automatic test_fill();
        int exp_pat [8] = '{1, 4, 7, 2, 5, 0, 3, 6};
        int exp_tok [8] = '{1, 5, 5, 1, 1, 5, 5, 1};
        int s, p, t;
        for (int i = 0; i < 8; i++) begin
            s = model_entry(p, t);
            send(1'b1, 1'b0, 3'd0, 3'd0);
            checks++;
            if (o_tv_cnt != 1 || o_tv_lat != 3 || o_rej_cnt != 0) begin
                failures++;
                $display("FAIL fill_timing[%0d]: tv_cnt=%0d lat=%0d rej=%0d, required 1/3/0", i, o_tv_cnt, o_tv_lat, o_rej_cnt);
            end
            checks++;
            if (o_pn !== 3'(i) || o_pat !== 3'(exp_pat[i]) || o_tok !== 3'(exp_tok[i]) || o_tslot !== 3'(i) || s != i || p != exp_pat[i]) begin
                failures++;
                $display("FAIL fill_ticket[%0d]: pn=%0d pat=%0d tok=%0d tslot=%0d, required %0d/%0d/%0d/%0d",
                         i, o_pn, o_pat, o_tok, o_tslot, i, exp_pat[i], exp_tok[i], i);
            end
            checks++;
            if (bus.free_count !== 4'(7 - i)) begin
                failures++;
                $display("FAIL fill_free[%0d]: free=%0d, required %0d", i, bus.free_count, 7 - i);
            end
        end
        checks++;
        if (bus.entry_full !== 1'b1 || bus.occupancy !== 8'hFF) begin
            failures++;
            $display("FAIL fill_full: full=%b occ=%h, required 1/ff", bus.entry_full, bus.occupancy);
        end
        s = model_entry(p, t);
        send(1'b1, 1'b0, 3'd0, 3'd0);
        checks++;
        if (o_rej_cnt != 1 || o_rej_lat != 2 || o_tv_cnt != 0 || bus.occupancy !== 8'hFF || s != -1) begin
            failures++;
            $display("FAIL full_reject: rej_cnt=%0d lat=%0d tv=%0d occ=%h, required 1/2/0/ff", o_rej_cnt, o_rej_lat, o_tv_cnt, bus.occupancy);
        end
    endtask

    task automatic test_exit();
        int s, p, t;
        bit g;
        g = model_exit(1, 5);
        send(1'b0, 1'b1, 3'd1, 3'd5);
        checks++;
        if (o_ok_cnt != 1 || o_ok_lat != 2 || o_err_cnt != 0 || bus.occupancy !== 8'hFD || bus.free_count !== 4'd1 || !g) begin
            failures++;
            $display("FAIL exit_good: ok=%0d lat=%0d err=%0d occ=%h free=%0d, required 1/2/0/fd/1", o_ok_cnt, o_ok_lat, o_err_cnt, bus.occupancy, bus.free_count);
        end
        s = model_entry(p, t);
        send(1'b1, 1'b0, 3'd0, 3'd0);
        checks++;
        if (o_tv_cnt != 1 || o_tslot !== 3'd1 || o_pat !== 3'd1 || o_tok !== 3'd0 || s != 1) begin
            failures++;
            $display("FAIL reuse_slot: tv=%0d slot=%0d pat=%0d tok=%0d, required 1/1/1/0", o_tv_cnt, o_tslot, o_pat, o_tok);
        end
        g = model_exit(2, 0);
        send(1'b0, 1'b1, 3'd2, 3'd0);
        checks++;
        if (o_err_cnt != 1 || o_err_lat != 2 || o_ok_cnt != 0 || bus.occupancy !== 8'hFF || g) begin
            failures++;
            $display("FAIL exit_bad_token: err=%0d lat=%0d ok=%0d occ=%h, required 1/2/0/ff", o_err_cnt, o_err_lat, o_ok_cnt, bus.occupancy);
        end
        g = model_exit(3, 1);
        send(1'b0, 1'b1, 3'd3, 3'd1);
        g = model_exit(3, 1);
        send(1'b0, 1'b1, 3'd3, 3'd1);
        checks++;
        if (o_err_cnt != 1 || o_ok_cnt != 0 || bus.occupancy !== 8'hF7 || g) begin
            failures++;
            $display("FAIL exit_unoccupied: err=%0d ok=%0d occ=%h, required 1/0/f7", o_err_cnt, o_ok_cnt, bus.occupancy);
        end
    endtask

    task automatic test_simultaneous();
        int s, p, t;
        bit g;
        s = model_entry(p, t);
        send(1'b1, 1'b0, 3'd0, 3'd0);
        g = model_exit(0, 0 ^ m_slot_pat[0]);
        s = model_entry(p, t);
        send(1'b1, 1'b1, 3'd0, 3'(0 ^ 1));
        checks++;
        if (o_ok_cnt != 1 || o_ok_lat != 2 || o_tv_cnt != 1 || o_tv_lat != 5 || o_rej_cnt != 0 || !g) begin
            failures++;
            $display("FAIL simul_order: ok=%0d@%0d tv=%0d@%0d rej=%0d, required 1@2 1@5 0", o_ok_cnt, o_ok_lat, o_tv_cnt, o_tv_lat, o_rej_cnt);
        end
        checks++;
        if (o_tslot !== 3'd0 || o_tok !== 3'(t) || s != 0 || bus.occupancy !== 8'hFF) begin
            failures++;
            $display("FAIL simul_ticket: slot=%0d tok=%0d occ=%h, required 0/%0d/ff", o_tslot, o_tok, bus.occupancy, t);
        end
    endtask

    task automatic test_reset_alloc();
        int tv = 0;
        bit g;
        g = model_exit(4, 4 ^ m_slot_pat[4]);
        send(1'b0, 1'b1, 3'd4, 3'(4 ^ m_slot_pat[4]));
        @(negedge clk);
        bus.entry_req = 1'b1;
        @(negedge clk);
        bus.entry_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.park_number !== 3'd4) begin
            failures++;
            $display("FAIL alloc_slot: park_number=%0d, required 4", bus.park_number);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            if (bus.token_valid) tv++;
            @(negedge clk);
        end
        checks++;
        if (tv != 0 || bus.occupancy !== 8'h00 || bus.free_count !== 4'(NUM_SLOTS) || bus.park_number !== 3'd0
            || bus.pattern !== 3'd0 || bus.token_out !== 3'd0 || bus.token_slot !== 3'd0) begin
            failures++;
            $display("FAIL alloc_abort: tv=%0d occ=%h free=%0d pn=%0d pat=%0d tok=%0d, required 0/00/%0d/0/0/0",
                     tv, bus.occupancy, bus.free_count, bus.park_number, bus.pattern, bus.token_out, NUM_SLOTS);
        end
        send(1'b1, 1'b0, 3'd0, 3'd0);
        checks++;
        if (o_tv_cnt != 1 || o_tslot !== 3'd0 || o_pat !== 3'd1 || o_tok !== 3'd1) begin
            failures++;
            $display("FAIL post_abort_entry: tv=%0d slot=%0d pat=%0d tok=%0d, required 1/0/1/1", o_tv_cnt, o_tslot, o_pat, o_tok);
        end
        begin
            int p, t, s;
            s = model_entry(p, t);
        end
    endtask

    task automatic test_random();
        int s, p, t, slot, tok;
        bit g;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                s = model_entry(p, t);
                send(1'b1, 1'b0, 3'd0, 3'd0);
                checks++;
                if (s < 0) begin
                    if (o_rej_cnt != 1 || o_rej_lat != 2 || o_tv_cnt != 0) begin
                        failures++;
                        $display("FAIL rand_reject[%0d]: rej=%0d@%0d tv=%0d, required 1@2 0", n, o_rej_cnt, o_rej_lat, o_tv_cnt);
                    end
                end else if (o_tv_cnt != 1 || o_tv_lat != 3 || o_rej_cnt != 0 || o_tslot !== 3'(s) || o_tok !== 3'(t) || o_pat !== 3'(p)) begin
                    failures++;
                    $display("FAIL rand_entry[%0d]: tv=%0d@%0d slot=%0d pat=%0d tok=%0d, required 1@3 %0d/%0d/%0d", n, o_tv_cnt, o_tv_lat, o_tslot, o_pat, o_tok, s, p, t);
                end
            end else begin
                slot = $urandom_range(0, 7);
                tok  = ($urandom_range(0, 2) != 0) ? (slot ^ m_slot_pat[slot]) : $urandom_range(0, 7);
                g = model_exit(slot, tok);
                send(1'b0, 1'b1, 3'(slot), 3'(tok));
                checks++;
                if (o_ok_cnt != int'(g) || o_err_cnt != int'(!g) || (g ? o_ok_lat : o_err_lat) != 2) begin
                    failures++;
                    $display("FAIL rand_exit[%0d]: slot=%0d tok=%0d ok=%0d err=%0d, required ok=%0d", n, slot, tok, o_ok_cnt, o_err_cnt, g);
                end
            end
            checks++;
            if (bus.occupancy !== model_occ_vec() || bus.free_count !== 4'(model_free()) || bus.entry_full !== (model_free() == 0)) begin
                failures++;
                $display("FAIL rand_state[%0d]: occ=%h free=%0d full=%b, required %h/%0d/%b", n, bus.occupancy, bus.free_count, bus.entry_full, model_occ_vec(), model_free(), model_free() == 0);
            end
        end
    endtask

    task automatic test_stats();
        logic [23:0] exp;
`ifdef PARK_ALLOC_STATS_EN
        exp = {8'(m_entries), 8'(m_rejects), 8'(m_errs)};
`else
        exp = 24'h0;
`endif
        checks++;
        if ({bus.stat_entries, bus.stat_rejects, bus.stat_exit_errs} !== exp) begin
            failures++;
            $display("FAIL stats: %0d/%0d/%0d, required %0d/%0d/%0d", bus.stat_entries, bus.stat_rejects, bus.stat_exit_errs, exp[23:16], exp[15:8], exp[7:0]);
        end
    endtask

    initial begin
        bus.entry_req  = 1'b0;
        bus.exit_req   = 1'b0;
        bus.exit_slot  = 3'd0;
        bus.exit_token = 3'd0;
        model_reset();
        test_reset();
        test_fill();
        test_exit();
        test_simultaneous();
        test_reset_alloc();
        test_random();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
